// File: rtl/swd_xact_seq_if.sv
// Command/response and swdIF signal bundle for the SWD transaction sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface swd_xact_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr32;
  logic        cmd_rnw;
  logic        cmd_apndp;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_retries;

  logic [1:0]  swd_addr32;
  logic        swd_rnw;
  logic        swd_apndp;
  logic [31:0] swd_din;
  logic        swd_go;
  logic        swd_done;
  logic [2:0]  swd_ack;
  logic [31:0] swd_dout;
  logic        swd_err;

  modport slave (
    input  cmd_valid, cmd_addr32, cmd_rnw, cmd_apndp, cmd_wdata, rsp_ready,
           swd_done, swd_ack, swd_dout, swd_err,
    output cmd_ready, rsp_valid, rsp_status, rsp_ack, rsp_rdata, rsp_retries,
           swd_addr32, swd_rnw, swd_apndp, swd_din, swd_go
  );

  modport master (
    output cmd_valid, cmd_addr32, cmd_rnw, cmd_apndp, cmd_wdata, rsp_ready,
           swd_done, swd_ack, swd_dout, swd_err,
    input  cmd_ready, rsp_valid, rsp_status, rsp_ack, rsp_rdata, rsp_retries,
           swd_addr32, swd_rnw, swd_apndp, swd_din, swd_go
  );
endinterface

// File: rtl/swd_xact_seq.sv
// SWD transaction sequencer: one DP/AP access at a time, WAIT retry with back-off, classified response.
// Define SWD_POSTED_READ_EN to complete AP reads with a trailing DP RDBUFF read.
module swd_xact_seq #(
  parameter int MAX_RETRY = 15,
  parameter int BACKOFF   = 16
) (
  input  logic          clk,
  input  logic          rst,
  swd_xact_seq_if.slave bus
);

  localparam logic [2:0] ACK_OK    = 3'b100;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b001;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_FAULT   = 3'd1;
  localparam logic [2:0] ST_TIMEOUT = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_PROTO   = 3'd4;

  localparam logic [7:0]  MAX_RETRY_W  = 8'(MAX_RETRY);
  localparam logic [15:0] BACKOFF_LAST = 16'(BACKOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_EVAL,
    S_BACKOFF,
`ifdef SWD_POSTED_READ_EN
    S_RDBUFF,
`endif
    S_RESP
  } state_t;

  state_t      state;
  logic [7:0]  retries;
  logic [15:0] backoff_cnt;
  logic        accept;
  logic        parity_bad;
  logic        ok_ack;
  logic        wait_retry;
  logic        need_rdbuff;

  // Failure classification once OK and retryable WAIT have been ruled out.
  function automatic logic [2:0] fail_status(input logic parity, input logic [2:0] ack);
    if (parity)                 return ST_PARITY;
    else if (ack == ACK_WAIT)   return ST_TIMEOUT;
    else if (ack == ACK_FAULT)  return ST_FAULT;
    else                        return ST_PROTO;
  endfunction

  assign bus.cmd_ready = rst && (state == S_IDLE) && bus.swd_done;
  assign accept        = bus.cmd_valid && (state == S_IDLE) && bus.swd_done;
  assign parity_bad    = bus.swd_rnw && bus.swd_err;
  assign ok_ack        = !parity_bad && (bus.swd_ack == ACK_OK);
  assign wait_retry    = !parity_bad && (bus.swd_ack == ACK_WAIT) && (retries < MAX_RETRY_W);

`ifdef SWD_POSTED_READ_EN
  logic rdbuff_phase;
  assign need_rdbuff = !rdbuff_phase && bus.swd_rnw && bus.swd_apndp;
`else
  assign need_rdbuff = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      retries         <= '0;
      backoff_cnt     <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_status  <= '0;
      bus.rsp_ack     <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_retries <= '0;
      bus.swd_addr32  <= '0;
      bus.swd_rnw     <= 1'b0;
      bus.swd_apndp   <= 1'b0;
      bus.swd_din     <= '0;
      bus.swd_go      <= 1'b0;
`ifdef SWD_POSTED_READ_EN
      rdbuff_phase    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.swd_addr32 <= bus.cmd_addr32;
            bus.swd_rnw    <= bus.cmd_rnw;
            bus.swd_apndp  <= bus.cmd_apndp;
            bus.swd_din    <= bus.cmd_wdata;
            bus.swd_go     <= 1'b1;
            retries        <= '0;
`ifdef SWD_POSTED_READ_EN
            rdbuff_phase   <= 1'b0;
`endif
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.swd_done) begin
            bus.swd_go <= 1'b0;
            state      <= S_RUN;
          end
        end

        S_RUN: begin
          if (bus.swd_done) state <= S_EVAL;
        end

        S_EVAL: begin
          if (ok_ack && need_rdbuff) begin
`ifdef SWD_POSTED_READ_EN
            state <= S_RDBUFF;
`endif
          end else if (wait_retry) begin
            retries     <= retries + 8'd1;
            backoff_cnt <= BACKOFF_LAST;
            state       <= S_BACKOFF;
          end else begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_ack     <= bus.swd_ack;
            bus.rsp_retries <= retries;
            if (ok_ack) begin
              bus.rsp_status <= ST_OK;
              bus.rsp_rdata  <= bus.swd_rnw ? bus.swd_dout : 32'd0;
            end else begin
              bus.rsp_status <= fail_status(parity_bad, bus.swd_ack);
              bus.rsp_rdata  <= 32'd0;
            end
            state <= S_RESP;
          end
        end

        S_BACKOFF: begin
          if (backoff_cnt == 16'd0) begin
            bus.swd_go <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            backoff_cnt <= backoff_cnt - 16'd1;
          end
        end

`ifdef SWD_POSTED_READ_EN
        // Second phase fetches the posted AP read result from DP RDBUFF.
        S_RDBUFF: begin
          bus.swd_addr32 <= 2'b11;
          bus.swd_apndp  <= 1'b0;
          bus.swd_rnw    <= 1'b1;
          rdbuff_phase   <= 1'b1;
          bus.swd_go     <= 1'b1;
          state          <= S_ISSUE;
        end
`endif

        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swd_xact_seq.sv
// Directed bench for swd_xact_seq: scripted swdIF target, rule-level response model, per-cycle compare.
`timescale 1ns/1ps
module tb_swd_xact_seq;
  localparam int MAX_RETRY = 3;
  localparam int BACKOFF   = 16;
  localparam logic [2:0] ACK_OK    = 3'b100;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b001;
`ifdef SWD_POSTED_READ_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  ack;
    logic [31:0] dout;
    logic        err;
  } resp_t;

  typedef struct {
    logic [1:0] addr;
    logic       apndp;
    logic       rnw;
    logic       after_wait;
    logic       chk_din;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  swd_xact_seq_if bus();
  swd_xact_seq #(.MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  resp_t       script[$];
  txn_t        exp_txn[$];
  int          run_len = 3;
  logic        force_busy = 1'b0;
  logic        armed = 1'b0;
  string       cur_tag = "idle";
  logic [31:0] exp_din = '0;
  int          go_count = 0;

  logic [2:0]  m_status;
  logic [2:0]  m_ack;
  logic [31:0] m_rdata;
  logic [7:0]  m_retries;
  int          m_txns;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] ack, input logic [31:0] dout, input logic err);
    resp_t r;
    r.ack = ack; r.dout = dout; r.err = err;
    script.push_back(r);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Response rules applied to the scripted acks: what the sequencer must return and issue.
  task automatic model(input logic [1:0] addr, input logic rnw, input logic apndp);
    resp_t r;
    txn_t  t;
    int    i = 0;
    int    tries = 0;
    bit    second = 0;
    bit    fin = 0;
    bit    after_wait = 0;
    logic [1:0] a = addr;
    logic ap = apndp;
    logic rd = rnw;
    exp_txn.delete();
    while (!fin) begin
      if (i < script.size()) r = script[i];
      else begin r.ack = ACK_WAIT; r.dout = '0; r.err = 1'b0; end
      t.addr = a; t.apndp = ap; t.rnw = rd; t.after_wait = after_wait; t.chk_din = !second;
      exp_txn.push_back(t);
      i++;
      after_wait = 0;
      m_ack = r.ack;
      m_rdata = '0;
      if (rd && r.err) begin
        m_status = 3'd3; fin = 1;
      end else if (r.ack == ACK_OK) begin
        if (POSTED && !second && rd && ap) begin
          second = 1; a = 2'b11; ap = 1'b0; rd = 1'b1;
        end else begin
          m_status = 3'd0; m_rdata = rd ? r.dout : 32'd0; fin = 1;
        end
      end else if (r.ack == ACK_WAIT && tries < MAX_RETRY) begin
        tries++; after_wait = 1;
      end else if (r.ack == ACK_WAIT) begin
        m_status = 3'd2; fin = 1;
      end else if (r.ack == ACK_FAULT) begin
        m_status = 3'd1; fin = 1;
      end else begin
        m_status = 3'd4; fin = 1;
      end
    end
    m_retries = 8'(tries);
    m_txns = i;
  endtask

  // swdIF stand-in: go while idle starts a transfer of run_len cycles, then presents the next scripted ack.
  initial begin : target
    resp_t r;
    bit aborted;
    bus.swd_done = 1'b1; bus.swd_ack = '0; bus.swd_dout = '0; bus.swd_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) bus.swd_done = 1'b1;
      else if (bus.swd_go && bus.swd_done) begin
        bus.swd_done = 1'b0;
        aborted = 0;
        for (int i = 0; i < run_len; i++) begin
          @(posedge clk); #1;
          if (!rst) begin aborted = 1; break; end
        end
        if (!aborted) begin
          if (script.size() > 0) r = script.pop_front();
          else begin r.ack = ACK_WAIT; r.dout = '0; r.err = 1'b0; end
          bus.swd_ack = r.ack; bus.swd_dout = r.dout; bus.swd_err = r.err;
        end
        bus.swd_done = 1'b1;
      end else bus.swd_done = !force_busy;
    end
  end

  initial begin : compare
    txn_t t;
    logic prev_go = 1'b0;
    int   fall_cycle = 0;
    forever begin
      @(negedge clk);
      if (bus.swd_go && !prev_go) begin
        go_count++;
        if (exp_txn.size() == 0) check({cur_tag, ".unexpected_go"}, 32'd1, 32'd0);
        else begin
          t = exp_txn.pop_front();
          check({cur_tag, ".swd_addr32"}, 32'(bus.swd_addr32), 32'(t.addr));
          check({cur_tag, ".swd_apndp"}, 32'(bus.swd_apndp), 32'(t.apndp));
          check({cur_tag, ".swd_rnw"}, 32'(bus.swd_rnw), 32'(t.rnw));
          if (t.chk_din) check({cur_tag, ".swd_din"}, bus.swd_din, exp_din);
          if (t.after_wait) check({cur_tag, ".retry_gap_ge_17"}, 32'((cycle - fall_cycle) >= BACKOFF + 1), 32'd1);
        end
      end
      if (!bus.swd_go && prev_go) fall_cycle = cycle;
      prev_go = bus.swd_go;
      if (armed && bus.rsp_valid) begin
        check({cur_tag, ".rsp_status"}, 32'(bus.rsp_status), 32'(m_status));
        check({cur_tag, ".rsp_ack"}, 32'(bus.rsp_ack), 32'(m_ack));
        check({cur_tag, ".rsp_rdata"}, bus.rsp_rdata, m_rdata);
        check({cur_tag, ".rsp_retries"}, 32'(bus.rsp_retries), 32'(m_retries));
        check({cur_tag, ".cmd_ready_in_resp"}, 32'(bus.cmd_ready), 32'd0);
      end
    end
  end

  task automatic do_cmd(input string tag, input logic [1:0] addr, input logic rnw,
                        input logic apndp, input logic [31:0] wd, input int hold);
    int start;
    int n;
    cur_tag = tag;
    model(addr, rnw, apndp);
    exp_din = wd;
    start = go_count;
    armed = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_addr32 = addr; bus.cmd_rnw = rnw;
    bus.cmd_apndp = apndp; bus.cmd_wdata = wd;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin step(); n++; end
    check({tag, ".accepted"}, 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 2000) begin step(); n++; end
    check({tag, ".rsp_arrived"}, 32'(bus.rsp_valid), 32'd1);
    repeat (hold) step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    armed = 1'b0;
    check({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".go_pulses"}, 32'(go_count - start), 32'(m_txns));
    check({tag, ".txns_left"}, 32'(exp_txn.size()), 32'd0);
    script.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".swd_go"}, 32'(bus.swd_go), 32'd0);
    check({tag, ".rsp_status"}, 32'(bus.rsp_status), 32'd0);
    check({tag, ".rsp_ack"}, 32'(bus.rsp_ack), 32'd0);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, ".rsp_retries"}, 32'(bus.rsp_retries), 32'd0);
    check({tag, ".swd_addr32"}, 32'(bus.swd_addr32), 32'd0);
    check({tag, ".swd_rnw"}, 32'(bus.swd_rnw), 32'd0);
    check({tag, ".swd_apndp"}, 32'(bus.swd_apndp), 32'd0);
    check({tag, ".swd_din"}, bus.swd_din, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int start;
    bus.cmd_valid = 1'b0; bus.cmd_addr32 = '0; bus.cmd_rnw = 1'b0;
    bus.cmd_apndp = 1'b0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("post_reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();

    // DP write, response held 20 cycles
    push(ACK_OK, 32'h0, 1'b0);
    do_cmd("dp_write", 2'b01, 1'b0, 1'b0, 32'h12345678, 20);
    check("dp_write.pin_status", 32'(m_status), 32'd0);
    check("dp_write.pin_rdata", m_rdata, 32'd0);
    check("dp_write.pin_retries", 32'(m_retries), 32'd0);
    check("dp_write.pin_txns", 32'(m_txns), 32'd1);

    // AP read: posted data first, RDBUFF data second when enabled
    push(ACK_OK, 32'h11111111, 1'b0);
`ifdef SWD_POSTED_READ_EN
    push(ACK_OK, 32'habcdef12, 1'b0);
`endif
    do_cmd("ap_read", 2'b01, 1'b1, 1'b1, 32'h0, 0);
`ifdef SWD_POSTED_READ_EN
    check("ap_read.pin_txns", 32'(m_txns), 32'd2);
    check("ap_read.pin_rdata", m_rdata, 32'habcdef12);
`else
    check("ap_read.pin_txns", 32'(m_txns), 32'd1);
    check("ap_read.pin_rdata", m_rdata, 32'h11111111);
`endif

    push(ACK_WAIT, 32'h0, 1'b0);
    push(ACK_WAIT, 32'h0, 1'b0);
    push(ACK_OK, 32'hcafef00d, 1'b0);
    do_cmd("wait2_ok", 2'b10, 1'b1, 1'b0, 32'h0, 2);
    check("wait2_ok.pin_status", 32'(m_status), 32'd0);
    check("wait2_ok.pin_retries", 32'(m_retries), 32'd2);
    check("wait2_ok.pin_txns", 32'(m_txns), 32'd3);
    check("wait2_ok.pin_rdata", m_rdata, 32'hcafef00d);

    repeat (4) push(ACK_WAIT, 32'h0, 1'b0);
    do_cmd("wait_timeout", 2'b00, 1'b0, 1'b0, 32'h0badcafe, 1);
    check("wait_timeout.pin_status", 32'(m_status), 32'd2);
    check("wait_timeout.pin_retries", 32'(m_retries), 32'd3);
    check("wait_timeout.pin_txns", 32'(m_txns), 32'd4);

    push(ACK_OK, 32'hdeadbeef, 1'b1);
    do_cmd("parity", 2'b11, 1'b1, 1'b0, 32'h0, 0);
    check("parity.pin_status", 32'(m_status), 32'd3);
    check("parity.pin_rdata", m_rdata, 32'd0);

    push(ACK_OK, 32'h0, 1'b1);
    do_cmd("write_err_ignored", 2'b10, 1'b0, 1'b0, 32'h5a5a5a5a, 0);
    check("write_err_ignored.pin_status", 32'(m_status), 32'd0);

    push(3'b111, 32'h0, 1'b0);
    do_cmd("proto", 2'b00, 1'b0, 1'b1, 32'h00000001, 0);
    check("proto.pin_status", 32'(m_status), 32'd4);

    push(ACK_FAULT, 32'h0, 1'b0);
    do_cmd("fault", 2'b01, 1'b0, 1'b1, 32'h00000002, 0);
    check("fault.pin_status", 32'(m_status), 32'd1);

    // Busy engine: command must wait
    cur_tag = "busy";
    start = go_count;
    force_busy = 1'b1;
    step(); step();
    bus.cmd_valid = 1'b1; bus.cmd_addr32 = 2'b01; bus.cmd_rnw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    step();
    bus.cmd_valid = 1'b0;
    step();
    force_busy = 1'b0;
    step(); step();
    check("busy.no_go", 32'(go_count - start), 32'd0);
    check("busy.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset asserted while the transfer is running
    cur_tag = "reset_run";
    run_len = 12;
    push(ACK_OK, 32'h5555aaaa, 1'b0);
    model(2'b10, 1'b1, 1'b0);
    exp_din = 32'h0;
    bus.cmd_valid = 1'b1; bus.cmd_addr32 = 2'b10; bus.cmd_rnw = 1'b1;
    bus.cmd_apndp = 1'b0; bus.cmd_wdata = 32'h0;
    step();
    bus.cmd_valid = 1'b0;
    step(); step();
    check("reset_run.in_run_go", 32'(bus.swd_go), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_run");
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_run.idle_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("reset_run.no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("reset_run.no_go", 32'(bus.swd_go), 32'd0);
    script.delete();
    exp_txn.delete();
    run_len = 3;
    step();

    push(ACK_OK, 32'h0badf00d, 1'b0);
    do_cmd("after_reset", 2'b11, 1'b1, 1'b0, 32'h0, 0);
    check("after_reset.pin_rdata", m_rdata, 32'h0badf00d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
